// File: rtl/collectible_spawner.sv
// collectible_spawner
//   Periodically requests a collectible type from the random type generator.
//   It places the collectible into the lowest-index free slot at the supplied
//   random position. It detects player pickups on game ticks and publishes the
//   slot state for rendering and pickup events for scoring.
//
//   Optional feature macro: COLLECTIBLE_LIFETIME_EN
//     defined   - each active slot has a lifetime counter that decrements on
//                 tick; the slot is cleared silently when the counter expires.
//     undefined - collectibles persist until picked up (LIFETIME unused).
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   tick            one-cycle game frame pulse
//   random_type     generator output, valid two cycles after gen_en
//   spawn_x/y       random spawn position, sampled in PLACE
//   player_x/y      current player position
//   gen_en          one-cycle enable to the type generator
//   slot_active     bit i set when slot i is occupied
//   slot_type/x/y   flattened per-slot type (0 when free) and position
//   collected       one-cycle pickup pulse
//   collected_type  type of the most recent pickup (held)
module collectible_spawner #(
    parameter int unsigned NUM_SLOTS      = 4,
    parameter int unsigned SPAWN_INTERVAL = 50,
    parameter int unsigned LIFETIME       = 200,
    parameter int unsigned HIT_RADIUS     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [1:0]               random_type,
    input  logic [6:0]               spawn_x,
    input  logic [5:0]               spawn_y,
    input  logic [6:0]               player_x,
    input  logic [5:0]               player_y,
    output logic                     gen_en,
    output logic [NUM_SLOTS-1:0]     slot_active,
    output logic [2*NUM_SLOTS-1:0]   slot_type,
    output logic [7*NUM_SLOTS-1:0]   slot_x,
    output logic [6*NUM_SLOTS-1:0]   slot_y,
    output logic                     collected,
    output logic [1:0]               collected_type
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PLACE
    } state_t;

    localparam int unsigned   TW     = $clog2(SPAWN_INTERVAL);
    localparam logic [TW-1:0] T_LAST = TW'(SPAWN_INTERVAL - 1);
    localparam int unsigned   IW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [7:0]    RADIUS = 8'(HIT_RADIUS);

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 retry_q, retry_d;
    logic [NUM_SLOTS-1:0] active_q, active_d;
    logic [1:0]           type_q [NUM_SLOTS];
    logic [1:0]           type_d [NUM_SLOTS];
    logic [6:0]           x_q    [NUM_SLOTS];
    logic [6:0]           x_d    [NUM_SLOTS];
    logic [5:0]           y_q    [NUM_SLOTS];
    logic [5:0]           y_d    [NUM_SLOTS];
    logic                 collected_q, collected_d;
    logic [1:0]           ctype_q, ctype_d;

`ifdef COLLECTIBLE_LIFETIME_EN
    localparam int unsigned   LW        = (LIFETIME < 1) ? 1 : $clog2(LIFETIME + 1);
    localparam logic [LW-1:0] LIFE_INIT = LW'(LIFETIME);

    logic [LW-1:0] life_q [NUM_SLOTS];
    logic [LW-1:0] life_d [NUM_SLOTS];
`else
    logic unused_lifetime;
    assign unused_lifetime = ^LIFETIME;
`endif

    logic [NUM_SLOTS-1:0] hit;
    logic                 hit_any, free_any;
    logic [IW-1:0]        hit_idx, free_idx;

    // Operands are widened by one bit so the subtraction never wraps.
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            hit[i] = active_q[i]
                  && (abs_diff({1'b0, player_x}, {1'b0, x_q[i]}) <= RADIUS)
                  && (abs_diff({2'b0, player_y}, {2'b0, y_q[i]}) <= RADIUS);
        end
    end

    // Lowest-index hit and lowest-index free slot, both based on the
    // registered occupancy so PLACE never targets a slot cleared this cycle.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (hit[i] && !hit_any) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
            if (!active_q[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        active_d    = active_q;
        type_d      = type_q;
        x_d         = x_q;
        y_d         = y_q;
        collected_d = 1'b0;
        ctype_d     = ctype_q;
`ifdef COLLECTIBLE_LIFETIME_EN
        life_d      = life_q;

        // Expiry first; a pickup on the same slot below still reports it.
        if (tick) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (active_q[i]) begin
                    if (life_q[i] <= LW'(1)) begin
                        active_d[i] = 1'b0;
                        type_d[i]   = '0;
                        life_d[i]   = '0;
                    end else begin
                        life_d[i] = life_q[i] - LW'(1);
                    end
                end
            end
        end
`endif

        if (tick && hit_any) begin
            active_d[hit_idx] = 1'b0;
            type_d[hit_idx]   = '0;
            collected_d       = 1'b1;
            ctype_d           = type_q[hit_idx];
        end

        case (state_q)
            S_IDLE: begin
                // retry_q keeps the spawn pending while every slot is full.
                if (timer_q == T_LAST) begin
                    if (tick || retry_q) begin
                        if (free_any) begin
                            state_d = S_REQ;
                            timer_d = '0;
                            retry_d = 1'b0;
                        end else begin
                            retry_d = 1'b1;
                        end
                    end
                end else if (tick) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: state_d = S_PLACE;
            S_PLACE: begin
                if (free_any) begin
                    active_d[free_idx] = 1'b1;
                    type_d[free_idx]   = (random_type == 2'd0) ? 2'd1 : random_type;
                    x_d[free_idx]      = spawn_x;
                    y_d[free_idx]      = spawn_y;
`ifdef COLLECTIBLE_LIFETIME_EN
                    life_d[free_idx]   = LIFE_INIT;
`endif
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            retry_q     <= 1'b0;
            active_q    <= '0;
            collected_q <= 1'b0;
            ctype_q     <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                type_q[i] <= '0;
                x_q[i]    <= '0;
                y_q[i]    <= '0;
`ifdef COLLECTIBLE_LIFETIME_EN
                life_q[i] <= '0;
`endif
            end
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            active_q    <= active_d;
            collected_q <= collected_d;
            ctype_q     <= ctype_d;
            type_q      <= type_d;
            x_q         <= x_d;
            y_q         <= y_d;
`ifdef COLLECTIBLE_LIFETIME_EN
            life_q      <= life_d;
`endif
        end
    end

    assign gen_en         = (state_q == S_REQ);
    assign slot_active    = active_q;
    assign collected      = collected_q;
    assign collected_type = ctype_q;

    always_comb begin
        slot_type = '0;
        slot_x    = '0;
        slot_y    = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slot_type[2*i +: 2] = type_q[i];
            slot_x[7*i +: 7]    = x_q[i];
            slot_y[6*i +: 6]    = y_q[i];
        end
    end

endmodule

// File: doc/collectible_spawner.md
Name: collectible_spawner

Overview:
- Downstream consumer of the random collectible type generator.
- Every SPAWN_INTERVAL game ticks it pulses the generator enable, captures the returned type (1..3), and places a collectible into the lowest-index free slot at the supplied random position.
- It tracks per-slot lifetime and detects player pickup.
- It publishes slot state to the OLED renderer and pickup events to the score logic.

Parameters:
- NUM_SLOTS, 4: number of concurrent collectible slots (1..8).
- SPAWN_INTERVAL, 50: game ticks between spawn attempts (>=2).
- LIFETIME, 200: game ticks a collectible stays alive (only with COLLECTIBLE_LIFETIME_EN).
- HIT_RADIUS, 3: pickup distance in pixels, applied per axis, inclusive.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle game frame pulse.
- random_type  in  2  generator output; valid from the 2nd cycle after gen_en.
- spawn_x  in  7  random x position, 0..95; sampled in PLACE.
- spawn_y  in  6  random y position, 0..63; sampled in PLACE.
- player_x  in  7  player x position.
- player_y  in  6  player y position.
- gen_en  out  1  one-cycle enable to the type generator.
- slot_active  out  NUM_SLOTS  bit i set means slot i is occupied.
- slot_type  out  2*NUM_SLOTS  type of slot i at bits [2i+1:2i]; 0 when free.
- slot_x  out  7*NUM_SLOTS  x of slot i, flattened.
- slot_y  out  6*NUM_SLOTS  y of slot i, flattened.
- collected  out  1  one-cycle pickup pulse.
- collected_type  out  2  type picked up; held until the next pickup.

Behaviour:
- Reset: gen_en=0, collected=0, collected_type=0, all slot_active/type/x/y=0, spawn timer=0, FSM=IDLE, lifetimes=0.
- Spawn timer: increments on tick in IDLE.
  - At SPAWN_INTERVAL-1 with any slot free: go to REQ and clear the timer.
  - If all slots are full: timer holds at SPAWN_INTERVAL-1 and retries each cycle until a slot frees.
- FSM:
  - IDLE -> REQ on the condition above.
  - REQ: gen_en=1 for exactly this cycle; -> WAIT.
  - WAIT: generator registers the new type at the end of REQ; -> PLACE.
  - PLACE: take the lowest-index free slot at this cycle. Load type=random_type (a value of 0 is stored as 1), x=spawn_x, y=spawn_y, active=1, lifetime=LIFETIME. Then -> IDLE.
  - If no slot is free in PLACE (all filled meanwhile), the spawn is dropped and the FSM returns to IDLE.
- Ticks arriving during REQ/WAIT/PLACE are not counted toward the timer. Spawn latency from timer expiry to slot_active is 3 cycles.
- Pickup: evaluated on tick cycles only.
  - A slot hits if it is active, |player_x-slot_x|<=HIT_RADIUS and |player_y-slot_y|<=HIT_RADIUS. Use unsigned absolute difference, 1 extra bit of width.
  - Lowest-index hitting slot is cleared (active=0, type=0); collected=1 next cycle, collected_type=its type.
  - At most one pickup per tick; other overlapping slots are picked up on later ticks.
- Collision with PLACE: PLACE into a slot being cleared by pickup in the same cycle is not allowed. PLACE uses the free mask before this cycle's pickup.
- Reset mid-operation: returns to the reset state immediately; any pending gen_en request is abandoned.

Optional Feature:
- Macro COLLECTIBLE_LIFETIME_EN.
- Defined:
  - Each active slot's counter decrements on tick; at 0 the slot is cleared without a collected pulse.
  - Pickup and expiry on the same slot in the same tick: pickup wins, collected pulses.
- Undefined: no lifetime counters; collectibles persist until picked up; LIFETIME is ignored.

Test Plan:
- Reset then 49 ticks -> gen_en stays 0. 50th tick -> gen_en=1 for one cycle, then slot_active=0001 three cycles after the timer expires. With random_type=2, spawn_x=40, spawn_y=20 -> slot_type[1:0]=2, slot_x[6:0]=40, slot_y[5:0]=20.
- Fill all 4 slots (200 ticks), wait 60 more ticks -> no gen_en. Pick up slot 1 -> gen_en within 1 cycle, and the new collectible lands in slot 1.
- Slot 0 at (40,20), player (43,17) on tick -> collected=1 for one cycle, collected_type=2, slot_active[0]=0. Player at (44,20) -> no pickup.
- Slots 0 and 2 both overlap the player -> first tick clears slot 0, next tick clears slot 2; two separate collected pulses.
- random_type=0 captured in PLACE -> stored type=1.
- With COLLECTIBLE_LIFETIME_EN and LIFETIME=5 -> slot clears 5 ticks after spawn, collected stays 0. With pickup on the 5th tick -> collected=1.
